// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - register map, FSM states and init command list for the MAX7219 chain driver
package max7219_pkg;

  // MAX7219 register addresses
  localparam logic [7:0] REG_DECODE     = 8'h09;
  localparam logic [7:0] REG_INTENSITY  = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] REG_TEST       = 8'h0F;

  // Top-level FSM states
  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_SNAP   = 3'd1;
  localparam logic [2:0] ST_ROW    = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_INTENS = 3'd4;
  localparam logic [2:0] ST_SHUT   = 3'd5;

  localparam int INIT_LEN = 5;

  // Power-up command list: shutdown, decode, scan limit, intensity, test
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic blank,
                                            input logic [3:0] intens);
    case (idx)
      3'd0:    return {REG_SHUTDOWN, 7'b0, ~blank};
      3'd1:    return {REG_DECODE, 8'h00};
      3'd2:    return {REG_SCAN_LIMIT, 8'h07};
      3'd3:    return {REG_INTENSITY, 4'h0, intens};
      default: return {REG_TEST, 8'h00};
    endcase
  endfunction

  // Digit/row registers start at address 1
  function automatic logic [7:0] row_addr(input logic [2:0] r);
    return {5'b0, r} + 8'd1;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - shifts one CS-framed word MSB first with a fixed CS-high gap afterwards
module spi_frame_tx #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             done,
  output logic             sdo,
  output logic             cs_n,
  output logic             sck
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(2 * CLK_DIV);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] TX_GAP   = 2'd2;

  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(2 * CLK_DIV - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [1:0]       st;
  logic [DW-1:0]    div;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sh;

  // The shift register drains to zero, so data idles low between frames
  assign sdo  = sh[WIDTH-1];
  // Asserted in the cycle before CS rises so the caller can update on the same edge
  assign done = (st == TX_SHIFT) && (div == DIV_END) && (bit_cnt == LAST_BIT);

  // Bit timing: CLK_DIV cycles sck low, CLK_DIV high, next bit on the falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= TX_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
    end else begin
      case (st)
        TX_IDLE: begin
          if (start) begin
            st      <= TX_SHIFT;
            sh      <= word;
            div     <= '0;
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            sck     <= 1'b0;
          end
        end
        TX_SHIFT: begin
          if (div == DIV_RISE) begin
            sck <= 1'b1;
            div <= div + 1'b1;
          end else if (div == DIV_END) begin
            sck <= 1'b0;
            div <= '0;
            sh  <= {sh[WIDTH-2:0], 1'b0};
            if (bit_cnt == LAST_BIT) begin
              cs_n <= 1'b1;
              st   <= TX_GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        TX_GAP: begin
          // Return to idle one cycle early so the next CS fall lands after 2*CLK_DIV
          if (div == GAP_END) st <= TX_IDLE;
          else                div <= div + 1'b1;
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/max7219_chain.sv
// rtl/max7219_chain.sv - init, snapshot refresh and intensity/blank upkeep for a MAX7219 daisy chain
module max7219_chain
  import max7219_pkg::*;
#(
  parameter int NDEV          = 4,
  parameter int CLK_DIV       = 4,
  parameter int INTENSITY_RST = 8,
  parameter int REINIT_BITS   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [64*NDEV-1:0] data,
  input  logic [3:0]        intensity,
  input  logic              blank,
  output logic              busy,
  output logic              refresh_done,
  output logic              leds_out,
  output logic              leds_cs,
  output logic              leds_clk
);

  localparam int FW = 16 * NDEV;

  logic [2:0]             state;
  logic [2:0]             init_idx;
  logic [2:0]             row;
  logic [REINIT_BITS-1:0] refresh_cnt;
  logic [64*NDEV-1:0]     snap;
  logic [3:0]             init_int;
  logic [3:0]             rec_int;
  logic                   init_blank;
  logic                   rec_blank;
  logic [7:0]             cmd_val;
  logic [FW-1:0]          frame;
  logic                   tx_start;
  logic                   tx_done;

  // The transmitter only accepts start when idle, so holding it high is safe
  assign tx_start = (state == ST_INIT) || (state == ST_ROW) ||
                    (state == ST_SHUT) || (state == ST_INTENS);

  // Frame word: device NDEV-1 occupies the MSBs and is therefore shifted first
  always_comb begin
    frame = '0;
    for (int d = 0; d < NDEV; d++) begin
      case (state)
        ST_INIT:   frame[d*16 +: 16] = init_word(init_idx, init_blank, init_int);
        ST_ROW:    frame[d*16 +: 16] = {row_addr(row), snap[d*64 + int'(row)*8 +: 8]};
        ST_SHUT:   frame[d*16 +: 16] = {REG_SHUTDOWN, cmd_val};
        ST_INTENS: frame[d*16 +: 16] = {REG_INTENSITY, cmd_val};
        default:   frame[d*16 +: 16] = 16'h0000;
      endcase
    end
  end

  // Coherent copy of the LED bits, taken once per refresh
  always_ff @(posedge clk) begin
    if (!rst && state == ST_SNAP) snap <= data;
  end

  // Sequencer: init list, 8 row frames, then decide on re-init / shutdown / intensity
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      init_idx     <= '0;
      row          <= '0;
      refresh_cnt  <= '0;
      busy         <= 1'b1;
      refresh_done <= 1'b0;
      init_int     <= 4'(INTENSITY_RST);
      init_blank   <= blank;
      rec_int      <= 4'(INTENSITY_RST);
      rec_blank    <= 1'b0;
      cmd_val      <= '0;
    end else begin
      refresh_done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (tx_done) begin
            if (init_idx == 3'(INIT_LEN - 1)) begin
              busy      <= 1'b0;
              rec_int   <= init_int;
              rec_blank <= init_blank;
              state     <= ST_SNAP;
            end else begin
              init_idx <= init_idx + 1'b1;
            end
          end
        end
        ST_SNAP: begin
          row   <= '0;
          state <= ST_ROW;
        end
        ST_ROW: begin
          if (tx_done) begin
            if (row == 3'd7) begin
              refresh_done <= 1'b1;
              refresh_cnt  <= refresh_cnt + 1'b1;
              state        <= ST_CHECK;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (refresh_cnt == '0) begin
            init_idx   <= '0;
            init_int   <= intensity;
            init_blank <= blank;
            busy       <= 1'b1;
            state      <= ST_INIT;
          end else if (blank != rec_blank) begin
            cmd_val <= {7'b0, ~blank};
            state   <= ST_SHUT;
          end else if (intensity != rec_int) begin
            cmd_val <= {4'b0, intensity};
            state   <= ST_INTENS;
          end else begin
            state <= ST_SNAP;
          end
        end
        ST_SHUT: begin
          if (tx_done) begin
            rec_blank <= ~cmd_val[0];
            state     <= ST_CHECK;
          end
        end
        ST_INTENS: begin
          if (tx_done) begin
            rec_int <= cmd_val[3:0];
            state   <= ST_CHECK;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  spi_frame_tx #(
    .WIDTH   (FW),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .word  (frame),
    .done  (tx_done),
    .sdo   (leds_out),
    .cs_n  (leds_cs),
    .sck   (leds_clk)
  );

endmodule

// File: tb/tb_max7219_chain.sv
// tb/tb_max7219_chain.sv - scoreboard bench for max7219_chain
module tb_max7219_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [255:0] data;
  logic [3:0]   intensity;
  logic         blank;
  logic         busy, refresh_done, leds_out, leds_cs, leds_clk;

  logic         rst2;
  logic [63:0]  data2;
  logic [3:0]   intensity2;
  logic         blank2;
  logic         busy2, refresh_done2, leds_out2, leds_cs2, leds_clk2;

  max7219_chain #(.NDEV(4), .CLK_DIV(4), .INTENSITY_RST(8), .REINIT_BITS(10)) dut (
    .clk(clk), .rst(rst), .data(data), .intensity(intensity), .blank(blank),
    .busy(busy), .refresh_done(refresh_done), .leds_out(leds_out),
    .leds_cs(leds_cs), .leds_clk(leds_clk)
  );

  max7219_chain #(.NDEV(1), .CLK_DIV(2), .INTENSITY_RST(5), .REINIT_BITS(2)) dut2 (
    .clk(clk), .rst(rst2), .data(data2), .intensity(intensity2), .blank(blank2),
    .busy(busy2), .refresh_done(refresh_done2), .leds_out(leds_out2),
    .leds_cs(leds_cs2), .leds_clk(leds_clk2)
  );

  typedef struct packed {
    logic [63:0] frame;
    logic        busy;
    logic        rdone;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           frames_done = 0;
  int           mon_bits = 0;
  logic         collecting = 1'b0;
  logic         done2 = 1'b0;
  logic [255:0] data_a;
  logic [255:0] data_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input logic b, input logic rd);
    exp_t e;
    e.frame = {w, w, w, w};
    e.busy  = b;
    e.rdone = rd;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input logic [15:0] shut_w, input logic [15:0] int_w);
    push_word(shut_w,   1'b1, 1'b0);
    push_word(16'h0900, 1'b1, 1'b0);
    push_word(16'h0B07, 1'b1, 1'b0);
    push_word(int_w,    1'b1, 1'b0);
    push_word(16'h0F00, 1'b0, 1'b0);
  endtask

  task automatic push_rows(input logic [255:0] dv, input int first, input int last);
    exp_t e;
    for (int r = first; r <= last; r++) begin
      e.frame = '0;
      for (int d = 3; d >= 0; d--) e.frame = {e.frame[47:0], 8'(r + 1), dv[d*64 + r*8 +: 8]};
      e.busy  = 1'b0;
      e.rdone = (r == 7);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: decode each CS-low window from the pins and compare with the queue head
  initial begin : monitor
    logic        pcs, psck, gap_valid, period_bad;
    int          low_cnt, gap_cnt;
    logic [63:0] sh;
    exp_t        e;
    pcs = 1'b1; psck = 1'b0; gap_valid = 1'b0; period_bad = 1'b0;
    low_cnt = 0; gap_cnt = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        collecting = 1'b0;
        gap_valid  = 1'b0;
        mon_bits   = 0;
        pcs        = 1'b1;
        psck       = 1'b0;
      end else begin
        if (pcs && !leds_cs) begin
          if (gap_valid) check("cs_high_cycles", gap_cnt, 8);
          collecting = 1'b1;
          mon_bits   = 0;
          low_cnt    = 0;
          period_bad = 1'b0;
          sh         = '0;
        end
        if (!leds_cs) begin
          low_cnt++;
          if (!psck && leds_clk) begin
            if (low_cnt != 5 + 8 * mon_bits) period_bad = 1'b1;
            sh = {sh[62:0], leds_out};
            mon_bits++;
          end
        end else if (!pcs) begin
          collecting = 1'b0;
          frames_done++;
          gap_cnt   = 1;
          gap_valid = 1'b1;
          check("cs_low_cycles", low_cnt, 512);
          check("bits_per_frame", mon_bits, 64);
          check("bit_period", period_bad, 0);
          check("clk_low_at_cs_rise", leds_clk, 0);
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_word", sh, e.frame);
            check("busy_at_cs_rise", busy, e.busy);
            check("refresh_done_at_cs_rise", refresh_done, e.rdone);
          end
        end else begin
          gap_cnt++;
        end
        pcs  = leds_cs;
        psck = leds_clk;
      end
    end
  end

  task automatic count_init2(output int n);
    logic p;
    p = leds_cs2;
    n = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!p && leds_cs2) n++;
      p = leds_cs2;
      if (!busy2) break;
    end
  endtask

  // Second chain: re-init after every 4th refresh with busy raised during it
  initial begin : reinit_check
    int n, t;
    rst2 = 1'b1; data2 = 64'h0123_4567_89AB_CDEF; intensity2 = 4'd5; blank2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    count_init2(n);
    check("dut2_init_frames", n, 5);
    for (int k = 1; k <= 8; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!refresh_done2 && t < 3000);
      check("dut2_refresh_seen", refresh_done2, 1);
      @(negedge clk);
      @(negedge clk);
      check("dut2_busy_after_refresh", busy2, (k % 4 == 0));
      if (k % 4 == 0) begin
        count_init2(n);
        check("dut2_reinit_frames", n, 5);
      end
    end
    done2 = 1'b1;
  end

  // Main stimulus
  initial begin : stim
    int t;
    data_a = 256'h1;
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 8; r++)
        data_b[d*64 + r*8 +: 8] = 8'h80 | 8'(d << 4) | 8'(r);
    rst = 1'b1; data = data_a; intensity = 4'd8; blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", leds_cs, 1);
    check("rst_clk", leds_clk, 0);
    check("rst_out", leds_out, 0);
    check("rst_busy", busy, 1);
    check("rst_refresh_done", refresh_done, 0);

    push_init(16'h0C01, 16'h0A08);
    push_rows(data_a, 0, 7);
    push_rows(data_a, 0, 7);
    push_rows(data_b, 0, 7);
    push_rows(data_b, 0, 7);
    push_word(16'h0C00, 1'b0, 1'b0);
    push_word(16'h0A03, 1'b0, 1'b0);
    push_rows(data_b, 0, 1);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("cs_high_before_first_frame", leds_cs, 1);
    @(negedge clk);
    check("first_cs_fall", leds_cs, 0);

    // Mid-row-3 data change in the second refresh
    t = 0;
    while (frames_done < 16 && t < 20000) begin @(negedge clk); t++; end
    check("reached_row3", frames_done, 16);
    repeat (100) @(negedge clk);
    data = data_b;

    // Blank and intensity change within the fourth refresh
    t = 0;
    while (frames_done < 31 && t < 20000) begin @(negedge clk); t++; end
    check("reached_refresh4", frames_done, 31);
    intensity = 4'd3;
    blank     = 1'b1;

    // Reset at bit 20 of row 2 in the fifth refresh
    t = 0;
    while (!(frames_done >= 41 && collecting && mon_bits >= 20) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check("reached_bit20", mon_bits, 20);
    check("queue_before_reset", exp_q.size(), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_cs", leds_cs, 1);
    check("abort_clk", leds_clk, 0);
    check("abort_out", leds_out, 0);
    check("abort_busy", busy, 1);

    push_init(16'h0C00, 16'h0A08);
    push_rows(data_b, 0, 7);
    push_word(16'h0A03, 1'b0, 1'b0);
    push_rows(data_b, 0, 7);

    t = 0;
    while (exp_q.size() != 0 && t < 40000) begin @(negedge clk); t++; end
    check("all_frames_seen", exp_q.size(), 0);
    t = 0;
    while (!done2 && t < 20000) begin @(negedge clk); t++; end
    check("dut2_done", done2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max7219_chain.md
# max7219_chain

Parametrised driver for a daisy chain of NDEV MAX7219 8x8 LED matrix controllers. It is the generalised successor to the fixed 256-LED debug matrix on the board top level. It runs the power-up register sequence, refreshes all rows continuously from a coherent snapshot of a flat bit vector, and applies intensity, blanking and periodic re-initialisation. It sits at board top level and drives three GPIO pins: data, chip select and SPI clock.

## Interface
- NDEV, 4: number of chained devices, 1..8.
- CLK_DIV, 4: clk cycles per SPI half-period, >=2.
- INTENSITY_RST, 8: intensity used by the init sequence, 0..15.
- REINIT_BITS, 10: full init is re-sent every 2^REINIT_BITS completed refreshes.
- clk  in  1  system clock (24 MHz).
- rst  in  1  synchronous, active-high reset.
- data  in  64*NDEV  LED bits; device d, row r, column c = data[d*64 + r*8 + c].
- intensity  in  4  requested brightness.
- blank  in  1  1 = chain in shutdown, 0 = normal operation.
- busy  out  1  high while the init sequence runs.
- refresh_done  out  1  one-cycle pulse after row 7 has latched.
- leds_out  out  1  serial data, MSB first.
- leds_cs  out  1  active-low load/CS.
- leds_clk  out  1  SPI clock, idle low, device samples on rising edge.

## Operation
- Register addresses: row r = r+1; decode 0x9; intensity 0xA; scan limit 0xB; shutdown 0xC; test 0xF.
- A frame is NDEV 16-bit words {addr[7:0], value[7:0]} in one CS-low window.
- Device NDEV-1 is shifted first, so device 0 (nearest the FPGA) receives the last word.
- Row value byte = data[d*64 + r*8 + 7 : d*64 + r*8], bit 7 first.
- Command frames send the same word to every device.
- States: INIT -> SNAP -> ROW -> CHECK -> (INTENS | SHUT | INIT | SNAP).
- INIT: five frames in this order:
  - 0x0C01 (0x0C00 if blank)
  - 0x0900
  - 0x0B07
  - 0x0A, intensity value (INTENSITY_RST after rst, current `intensity` on re-init)
  - 0x0F00
  - After INIT: record the written intensity and blank values, drop busy, go to SNAP.
- SNAP: register all of `data` in one cycle. Rows 0..7 are then sent as 8 ROW frames from this snapshot.
  - Changes to `data` mid-refresh are not visible until the next SNAP.
- CHECK, after row 7: pulse refresh_done and increment the refresh counter (REINIT_BITS wide, wraps). Then take the first true item:
  1. counter wrapped to 0 -> INIT
  2. blank != recorded blank -> SHUT frame
  3. intensity != recorded intensity -> INTENS frame
  4. otherwise -> SNAP
- After a SHUT or INTENS frame, update the recorded value and return to CHECK, without incrementing the counter. Changes that happen on the same pass are therefore served one frame each, SHUT first.
- While blank is recorded as 1, rows are still refreshed.
- rst at any point: abort the current frame; the next cycle has leds_cs=1, leds_clk=0, leds_out=0. Restart INIT, clear the refresh counter, busy=1.

## Timing
- Reset values: leds_cs=1, leds_clk=0, leds_out=0, busy=1, refresh_done=0.
- First CS fall: 1 cycle after rst deasserts.
- Per bit: leds_out changes together with the falling edge of leds_clk (first bit: with CS fall). Then CLK_DIV cycles clk low, followed by CLK_DIV cycles clk high.
- CS stays low for 32*NDEV*CLK_DIV cycles. leds_clk is low when CS rises, and CS then stays high for 2*CLK_DIV cycles.
- Frame period: (32*NDEV+2)*CLK_DIV cycles; defaults give 520.
- No gap between frames beyond the CS-high time. SNAP and CHECK are absorbed into the CS-high time.
- busy falls in the cycle CS rises at the end of the 5th init frame.
- refresh_done pulses in the cycle CS rises after row 7.
- Refresh period in steady state: 8 frames.

## Structure
- Package max7219_pkg: register address constants, state enum, init command list.
- Sub-module spi_frame_tx (parameters WIDTH, CLK_DIV):
  - ports clk, rst, start, word[WIDTH-1:0], done, sdo, cs_n, sck
  - owns the bit counter (clog2(WIDTH)) and the divider
- Top FSM builds the 16*NDEV-bit frame word combinationally from state, row index and snapshot.

## Test plan
- Reset release, defaults: exactly 5 frames match the INIT list, with intensity word 0x0A08 on all 4 devices; busy falls at cycle 2600; first row frame follows.
- data with only bit 0 set (device 0, row 0, column 0): row-0 frame is 0x0100 x3 then 0x0101 (last 16 bits shifted); other rows are all 0x0r00.
- Change data in the middle of row 3: rows 3..7 still send old values; the next refresh shows the new values.
- intensity 8->3 and blank 0->1 in the same refresh: after row 7, frame 0x0C00 and then frame 0x0A03; then SNAP. Bit periods are 8 cycles, CS-high time is 8 cycles.
- REINIT_BITS=2: the full INIT sequence is re-sent after every 4th refresh_done; busy is high during it.
- rst pulsed at bit 20 of a frame: next cycle CS=1, clk=0; INIT restarts with intensity 0x0A08.
